fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the accumulator pipeline. It generalises the two-accumulator (A/B) forwarding logic to NREGS accumulators. It also tracks the EX and MEM stage occupants internally rather than taking their opcodes as inputs, and adds load-use stall generation, bubble insertion, flush and external hold, plus a saturating stall counter. It sits beside the ID/EX pipeline register and drives the EX-stage operand multiplexers and the PC/IF-ID enable.

---
 rtl/fwd_pkg.sv | 86 ++++++++
 rtl/fwd_stage_tracker.sv | 24 ++
 rtl/fwd_hazard_unit.sv | 73 +++++++
 tb/tb_fwd_hazard_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - opcode table, stage record and decode for the forwarding/hazard unit
package fwd_pkg;

  localparam int OP_BITS = 6;
  localparam int MAXREGS = 8;
  localparam int IDXW    = 3;

  // opcode = {class[2:0], accumulator index[2:0]}
  localparam logic [2:0] CLS_LD  = 3'd0;
  localparam logic [2:0] CLS_LDC = 3'd1;
  localparam logic [2:0] CLS_ST  = 3'd2;
  localparam logic [2:0] CLS_ADD = 3'd3;
  localparam logic [2:0] CLS_SUB = 3'd4;
  localparam logic [2:0] CLS_AND = 3'd5;
  localparam logic [2:0] CLS_OR  = 3'd6;

  localparam logic [OP_BITS-1:0] LDA  = 6'o00;
  localparam logic [OP_BITS-1:0] LDB  = 6'o01;
  localparam logic [OP_BITS-1:0] LDCA = 6'o10;
  localparam logic [OP_BITS-1:0] LDCB = 6'o11;
  localparam logic [OP_BITS-1:0] STA  = 6'o20;
  localparam logic [OP_BITS-1:0] STB  = 6'o21;
  localparam logic [OP_BITS-1:0] ADDA = 6'o30;
  localparam logic [OP_BITS-1:0] ADDB = 6'o31;
  localparam logic [OP_BITS-1:0] SUBA = 6'o40;
  localparam logic [OP_BITS-1:0] SUBB = 6'o41;
  localparam logic [OP_BITS-1:0] ANDA = 6'o50;
  localparam logic [OP_BITS-1:0] ANDB = 6'o51;
  localparam logic [OP_BITS-1:0] ORA  = 6'o60;
  localparam logic [OP_BITS-1:0] ORB  = 6'o61;
  localparam logic [OP_BITS-1:0] ASLA = 6'o70;
  localparam logic [OP_BITS-1:0] ASRA = 6'o71;

  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] dst_idx;
    logic            dst_we;
    logic            is_load;
  } stage_rec_t;

  typedef struct packed {
    logic [MAXREGS-1:0] src_mask;
    logic [IDXW-1:0]    dst_idx;
    logic               dst_we;
    logic               is_load;
  } dec_t;

  // Indices at or above nregs decode as unknown opcodes.
  function automatic dec_t decode(input logic [OP_BITS-1:0] op, input int nregs);
    dec_t       d;
    logic [2:0] cls;
    logic [2:0] idx;
    d   = '0;
    cls = op[5:3];
    idx = op[2:0];
    if (op == ASLA || op == ASRA) begin
      d.src_mask[0] = 1'b1;
      d.dst_we      = 1'b1;
    end else if (int'(idx) < nregs) begin
      case (cls)
        CLS_LD: begin
          d.dst_idx = idx;
          d.dst_we  = 1'b1;
          d.is_load = 1'b1;
        end
        CLS_LDC: begin
          d.dst_idx = idx;
          d.dst_we  = 1'b1;
        end
        CLS_ST: d.src_mask[idx] = 1'b1;
        CLS_ADD, CLS_SUB, CLS_AND, CLS_OR: begin
          d.src_mask[idx] = 1'b1;
          d.dst_idx       = idx;
          d.dst_we        = 1'b1;
        end
        default: ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/fwd_stage_tracker.sv
// rtl/fwd_stage_tracker.sv - EX/MEM occupant shift register with bubble, hold and reset
module fwd_stage_tracker
  import fwd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       advance,
  input  stage_rec_t id_rec,
  output stage_rec_t ex_q,
  output stage_rec_t mem_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!hold) begin
      mem_q <= ex_q;
      ex_q  <= advance ? id_rec : '0;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding selects, load-use stall and stall counter
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int OPW   = 6,
  parameter int NREGS = 2,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [OPW-1:0]     id_opcode,
  input  logic               id_hold,
  input  logic               flush,
  output logic [2*NREGS-1:0] fwd_sel,
  output logic               stall,
  output logic [CNTW-1:0]    stall_count
);

  dec_t               id_dec;
  stage_rec_t         id_rec;
  stage_rec_t         ex_q;
  stage_rec_t         mem_q;
  logic               advance;
  logic [2*NREGS-1:0] fwd_next;
  logic               unused_bits;

  always_comb id_dec = decode(OP_BITS'(id_opcode), NREGS);

  assign stall = id_valid & ex_q.valid & ex_q.is_load & ex_q.dst_we
               & id_dec.src_mask[ex_q.dst_idx] & ~flush;
  assign advance = id_valid & ~stall & ~flush;

  assign id_rec = '{valid: 1'b1, dst_idx: id_dec.dst_idx,
                    dst_we: id_dec.dst_we, is_load: id_dec.is_load};
  assign unused_bits = mem_q.is_load;

  fwd_stage_tracker u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (id_hold),
    .advance (advance),
    .id_rec  (id_rec),
    .ex_q    (ex_q),
    .mem_q   (mem_q)
  );

  // The EX producer is newer than the MEM one, so it is tested first.
  always_comb begin
    fwd_next = '0;
    if (advance) begin
      for (int r = 0; r < NREGS; r++) begin
        if (id_dec.src_mask[r] && ex_q.valid && ex_q.dst_we && !ex_q.is_load
            && ex_q.dst_idx == IDXW'(r))
          fwd_next[2*r +: 2] = FWD_EXMEM;
        else if (mem_q.valid && mem_q.dst_we && mem_q.dst_idx == IDXW'(r))
          fwd_next[2*r +: 2] = FWD_MEMWB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel     <= '0;
      stall_count <= '0;
    end else if (!id_hold) begin
      fwd_sel <= fwd_next;
      if (stall && stall_count != '1)
        stall_count <= stall_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - randomized and directed checks of two fwd_hazard_unit configurations
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_hold = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] id_opcode = 6'o77;
  logic [3:0] fwd0;
  logic [7:0] fwd1;
  logic       stall0, stall1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int passed = 0;
  int total  = 0;

  int         nr[2]   = '{2, 4};
  int         cmax[2] = '{65535, 3};
  bit         ex_v[2], mem_v[2];
  logic [5:0] ex_op[2], mem_op[2];
  int         efwd[2][4];
  int         ecnt[2];

  logic [5:0] op_pool[24] = '{LDA, LDA, LDB, LDB, LDCA, LDCB, STA, STB, ADDA, ADDB, SUBA, SUBB,
                              ANDA, ORB, ASLA, ASRA, 6'o02, 6'o03, 6'o33, 6'o43, 6'o23, 6'o62,
                              6'o77, 6'o72};

  fwd_hazard_unit #(.OPW(6), .NREGS(2), .CNTW(16)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_hold(id_hold), .flush(flush), .fwd_sel(fwd0), .stall(stall0), .stall_count(cnt0)
  );

  fwd_hazard_unit #(.OPW(6), .NREGS(4), .CNTW(2)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_hold(id_hold), .flush(flush), .fwd_sel(fwd1), .stall(stall1), .stall_count(cnt1)
  );

  always #5 clk = ~clk;

  // Reference semantics of the instruction set, written from the mnemonic table.
  function automatic bit m_writes(logic [5:0] op, int r, int n);
    int cls = int'(op) / 8;
    int idx = int'(op) % 8;
    if (op == ASLA || op == ASRA) return r == 0;
    if (idx >= n) return 0;
    if (cls == 0 || cls == 1 || (cls >= 3 && cls <= 6)) return idx == r;
    return 0;
  endfunction

  function automatic bit m_reads(logic [5:0] op, int r, int n);
    int cls = int'(op) / 8;
    int idx = int'(op) % 8;
    if (op == ASLA || op == ASRA) return r == 0;
    if (idx >= n) return 0;
    if (cls >= 2 && cls <= 6) return idx == r;
    return 0;
  endfunction

  function automatic bit m_load(logic [5:0] op, int n);
    return (int'(op) / 8 == 0) && (int'(op) % 8 < n);
  endfunction

  function automatic bit m_stall(int k);
    if (!id_valid || flush || !ex_v[k] || !m_load(ex_op[k], nr[k])) return 0;
    for (int r = 0; r < nr[k]; r++)
      if (m_writes(ex_op[k], r, nr[k]) && m_reads(id_opcode, r, nr[k])) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ex_v[k] = 0; mem_v[k] = 0; ecnt[k] = 0;
      for (int r = 0; r < 4; r++) efwd[k][r] = 0;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      int ef = 0;
      for (int r = 0; r < nr[k]; r++) ef += efwd[k][r] << (2 * r);
      chk($sformatf("u%0d.stall", k), k ? int'(stall1) : int'(stall0), int'(m_stall(k)));
      chk($sformatf("u%0d.fwd_sel", k), k ? int'(fwd1) : int'(fwd0), ef);
      chk($sformatf("u%0d.stall_count", k), k ? int'(cnt1) : int'(cnt0), ecnt[k]);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit s = m_stall(k);
      bit adv;
      if (!id_hold) begin
        adv = id_valid && !s && !flush;
        for (int r = 0; r < 4; r++) begin
          efwd[k][r] = 0;
          if (adv && r < nr[k]) begin
            if (m_reads(id_opcode, r, nr[k]) && ex_v[k] && m_writes(ex_op[k], r, nr[k]))
              efwd[k][r] = 1;
            else if (mem_v[k] && m_writes(mem_op[k], r, nr[k]))
              efwd[k][r] = 2;
          end
        end
        if (s && ecnt[k] < cmax[k]) ecnt[k]++;
        mem_v[k]  = ex_v[k];
        mem_op[k] = ex_op[k];
        ex_v[k]   = adv;
        ex_op[k]  = id_opcode;
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [5:0] op, input bit fl = 1'b0, input bit hd = 1'b0);
    @(negedge clk);
    id_valid = v; id_opcode = op; flush = fl; id_hold = hd;
    #1;
    model_check();
    model_step();
  endtask

  task automatic drain();
    repeat (3) cyc(1'b0, 6'o77);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // back-to-back ALU dependency forwards from EX/MEM
    cyc(1, ADDA); cyc(1, ADDA); cyc(0, 6'o77);
    chk("adda_adda_fwd", fwd0, 1);
    chk("adda_adda_fwd_n4", fwd1, 1);

    drain();
    cyc(1, ADDA); cyc(0, 6'o77); cyc(1, ADDA); cyc(0, 6'o77);
    chk("adda_gap_adda_fwd", fwd0, 2);

    drain();
    cyc(1, ADDA); cyc(1, ADDB); cyc(1, ADDA); cyc(0, 6'o77);
    chk("older_writer_fwd", fwd0, 2);

    // load-use: one stall, bubble, then MEM/WB forward
    drain();
    cyc(1, LDA); cyc(1, ADDA);
    chk("load_use_stall", stall0, 1);
    cyc(1, ADDA);
    chk("load_use_stall_once", stall0, 0);
    chk("load_use_bubble_fwd", fwd0, 0);
    cyc(0, 6'o77);
    chk("load_use_fwd", fwd0, 2);
    chk("load_use_count", cnt0, 1);

    // asynchronous reset mid-stream with a load in EX and a hazard pending
    drain();
    cyc(1, LDA);
    @(negedge clk);
    id_valid = 1; id_opcode = ADDA; flush = 0; id_hold = 0;
    #1;
    chk("pre_reset_stall", stall0, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_stall", stall0, 0);
    chk("reset_fwd", fwd0, 0);
    chk("reset_count", cnt0, 0);
    chk("reset_count_n4", cnt1, 0);
    @(negedge clk);
    id_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, ADDA); cyc(0, 6'o77);
    chk("post_reset_no_fwd", fwd0, 0);

    // flush wins over stall
    drain();
    cyc(1, LDA); cyc(1, ADDA, 1'b1);
    chk("flush_stall", stall0, 0);
    cyc(0, 6'o77);
    chk("flush_count", cnt0, 0);
    chk("flush_fwd", fwd0, 0);

    // hold during a load-use hazard
    drain();
    cyc(1, LDA);
    repeat (3) begin
      cyc(1, ADDA, 1'b0, 1'b1);
      chk("hold_stall", stall0, 1);
      chk("hold_count", cnt0, 0);
    end
    cyc(1, ADDA);
    cyc(1, ADDA);
    chk("hold_release_count", cnt0, 1);
    chk("hold_release_stall", stall0, 0);
    cyc(0, 6'o77);
    chk("hold_release_fwd", fwd0, 2);

    // fourth accumulator in the wide instance
    drain();
    cyc(1, 6'o33); cyc(1, 6'o33); cyc(0, 6'o77);
    chk("reg3_fwd_n4", fwd1, 8'h40);
    chk("reg3_unknown_n2", fwd0, 0);

    // four more stalls: narrow counter saturates
    drain();
    repeat (4) begin
      cyc(1, LDA); cyc(1, ADDA); cyc(1, ADDA);
    end
    cyc(0, 6'o77);
    chk("count_n2", cnt0, 5);
    chk("count_sat_n4", cnt1, 3);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(99) < 85, op_pool[$urandom_range(23)],
          $urandom_range(99) < 8, $urandom_range(99) < 8);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
